// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Load/store responder for the memory pipeline stage. Accepts one
//   byte/half/word request per transaction, waits LATENCY cycles, and then
//   performs the little-endian array access. It returns a single-cycle
//   response that carries the extended load data or an error flag.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned      load extension: 1 = zero, 0 = sign
//   req_write_data    right-aligned store data
//   resp_valid        one-cycle response strobe
//   resp_read_data    extended load data (0 for stores/errors)
//   resp_error        misaligned / reserved size / out of range
module data_memory_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;

    logic        cap_write;
    logic [31:0] cap_addr;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH];

    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   bit_mask;
    logic [31:0]   lanes;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic          do_write;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (LATENCY == 0) ? ACCESS : WAIT;
                end
            end
            WAIT:    if (cnt == 4'd1) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- capture and wait counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_size  <= '0;
            cap_uns   <= 1'b0;
            cap_wdata <= '0;
        end else begin
            if (accept) begin
                cnt       <= 4'(LATENCY);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_size  <= req_size;
                cap_uns   <= req_unsigned;
                cap_wdata <= req_write_data;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ---------------- access decode ----------------
    always_comb begin
        err = (cap_size == 2'b11)
            | ((cap_size == 2'b01) & cap_addr[0])
            | ((cap_size == 2'b10) & (|cap_addr[1:0]))
            | ({2'b00, cap_addr[31:2]} >= DEPTH);
        idx     = cap_addr[AW+1:2];
        rd_word = mem[idx];

        bit_mask = '0;
        lanes    = '0;
        case (cap_size)
            2'b00: begin
                bit_mask = 32'h0000_00FF << {cap_addr[1:0], 3'b000};
                lanes    = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                bit_mask = cap_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lanes    = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                bit_mask = '1;
                lanes    = cap_wdata;
            end
            default: ;
        endcase

        rd_byte = 8'(rd_word >> {cap_addr[1:0], 3'b000});
        rd_half = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = '0;
        case (cap_size)
            2'b00:   load_data = cap_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = cap_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            2'b10:   load_data = rd_word;
            default: load_data = '0;
        endcase

        // state is reset asynchronously, so a reset before the ACCESS edge
        // also suppresses the pending store.
        do_write = (state == ACCESS) & cap_write & ~err;
    end

    // Storage array: not reset; a read-modify-write merges the selected lanes.
    always_ff @(posedge clk) begin
        if (do_write) mem[idx] <= (rd_word & ~bit_mask) | (lanes & bit_mask);
    end

    // Response registers hold until the next ACCESS edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_error     <= 1'b0;
            resp_read_data <= '0;
        end else if (state == ACCESS) begin
            resp_error     <= err;
            resp_read_data <= (err | cap_write) ? '0 : load_data;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n3;
    logic        rv0, rv3, rdy0, rdy3;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_write_data;
    logic        resp_valid0, resp_valid3, resp_error0, resp_error3;
    logic [31:0] resp_data0, resp_data3;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(1024), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n0), .req_valid(rv0), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_write_data(req_write_data),
        .resp_valid(resp_valid0), .resp_read_data(resp_data0), .resp_error(resp_error0));

    data_memory_responder #(.DEPTH(1024), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(rv3), .req_ready(rdy3),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_write_data(req_write_data),
        .resp_valid(resp_valid3), .resp_read_data(resp_data3), .resp_error(resp_error3));

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$], q3[$];
    exp_t m0, m3;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare each response strobe against the queue head.
    always @(negedge clk) begin
        if (resp_valid0) begin
            if (q0.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_resp_L0: got resp_valid at cycle %0d, expected none", cyc);
            end else begin
                m0 = q0.pop_front();
                chk({m0.name, "_data"},  resp_data0, m0.data);
                chk({m0.name, "_error"}, 32'(resp_error0), 32'(m0.err));
                chk({m0.name, "_cycle"}, 32'(cyc), 32'(m0.cyc));
            end
        end
        if (resp_valid3) begin
            if (q3.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_resp_L3: got resp_valid at cycle %0d, expected none", cyc);
            end else begin
                m3 = q3.pop_front();
                chk({m3.name, "_data"},  resp_data3, m3.data);
                chk({m3.name, "_error"}, 32'(resp_error3), 32'(m3.err));
                chk({m3.name, "_cycle"}, 32'(cyc), 32'(m3.cyc));
            end
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd);
        req_write      = w;
        req_addr       = a;
        req_size       = sz;
        req_unsigned   = u;
        req_write_data = wd;
    endtask

    task automatic push(input bit sel, input string name, input logic eerr,
                        input logic [31:0] edata, input int c);
        exp_t e;
        e.err = eerr; e.data = edata; e.cyc = c; e.name = name;
        if (sel) q3.push_back(e);
        else     q0.push_back(e);
    endtask

    // Issue one request; acc returns the edge number of acceptance.
    task automatic issue(input bit sel, input string name, input logic w, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] wd,
                         input logic eerr, input logic [31:0] edata, input bit want,
                         output int acc);
        int n = 0;
        @(negedge clk);
        drive(w, a, sz, u, wd);
        if (sel) rv3 = 1'b1; else rv0 = 1'b1;
        while (!(sel ? rdy3 : rdy0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; fails++;
            $display("FAIL %s_accept: got no req_ready within 50 cycles, expected acceptance", name);
            rv0 = 1'b0; rv3 = 1'b0; acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        rv0 = 1'b0; rv3 = 1'b0;
        if (want) push(sel, name, eerr, edata, cyc + (sel ? 4 : 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; fails++;
            $display("FAIL drain: got %0d/%0d responses outstanding, expected 0", q0.size(), q3.size());
            q0.delete(); q3.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc, a0, a1, low;
        rst_n0 = 1'b0; rst_n3 = 1'b0; rv0 = 1'b0; rv3 = 1'b0;
        drive(1'b0, '0, 2'b10, 1'b0, '0);
        #2;
        chk("rst_ready_L0", 32'(rdy0), 32'd1);
        chk("rst_valid_L0", 32'(resp_valid0), 32'd0);
        chk("rst_error_L0", 32'(resp_error0), 32'd0);
        chk("rst_data_L0",  resp_data0, 32'd0);
        chk("rst_ready_L3", 32'(rdy3), 32'd1);
        chk("rst_valid_L3", 32'(resp_valid3), 32'd0);
        #10;
        rst_n0 = 1'b1; rst_n3 = 1'b1;

        // LATENCY = 0: basic store/load and extension
        issue(0, "st_word",   1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0,        1, acc);
        issue(0, "ld_word",   0, 32'h10, 2'b10, 0, 32'h0,        0, 32'hDEADBEEF, 1, acc);
        issue(0, "ld_b13_s",  0, 32'h13, 2'b00, 0, 32'h0,        0, 32'hFFFFFFDE, 1, acc);
        issue(0, "ld_b13_u",  0, 32'h13, 2'b00, 1, 32'h0,        0, 32'h000000DE, 1, acc);
        issue(0, "ld_h12_s",  0, 32'h12, 2'b01, 0, 32'h0,        0, 32'hFFFFDEAD, 1, acc);
        issue(0, "ld_h10_u",  0, 32'h10, 2'b01, 1, 32'h0,        0, 32'h0000BEEF, 1, acc);
        issue(0, "ld_b10_s",  0, 32'h10, 2'b00, 0, 32'h0,        0, 32'hFFFFFFEF, 1, acc);
        issue(0, "st_byte",   1, 32'h11, 2'b00, 0, 32'hFFFFFF55, 0, 32'h0,        1, acc);
        issue(0, "st_half",   1, 32'h12, 2'b01, 0, 32'hFFFF1234, 0, 32'h0,        1, acc);
        issue(0, "ld_merged", 0, 32'h10, 2'b10, 0, 32'h0,        0, 32'h123455EF, 1, acc);
        issue(0, "ld_h12_pos",0, 32'h12, 2'b01, 0, 32'h0,        0, 32'h00001234, 1, acc);
        drain();

        // Error cases
        issue(0, "err_st_mis",  1, 32'h12,   2'b10, 0, 32'hCAFECAFE, 1, 32'h0, 1, acc);
        issue(0, "err_ld_half", 0, 32'h11,   2'b01, 0, 32'h0,        1, 32'h0, 1, acc);
        issue(0, "err_size",    0, 32'h10,   2'b11, 0, 32'h0,        1, 32'h0, 1, acc);
        issue(0, "err_range",   0, 32'h1000, 2'b10, 0, 32'h0,        1, 32'h0, 1, acc);
        issue(0, "err_st_rng",  1, 32'h1010, 2'b10, 0, 32'h77777777, 1, 32'h0, 1, acc);
        issue(0, "ld_after_err",0, 32'h10,   2'b10, 0, 32'h0,        0, 32'h123455EF, 1, acc);
        drain();

        // LATENCY = 3: busy window, captured fields, back-to-back acceptance
        @(negedge clk);
        drive(1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D);
        rv3 = 1'b1;
        @(posedge clk);
        #1;
        a0 = cyc;
        push(1, "l3_store", 0, 32'h0, a0 + 4);
        drive(1'b0, 32'h40, 2'b10, 1'b0, 32'h0);
        low = 0;
        @(negedge clk);
        while (!rdy3 && low < 20) begin
            low++;
            @(negedge clk);
        end
        chk("l3_ready_low_cycles", 32'(low), 32'd5);
        @(posedge clk);
        #1;
        a1 = cyc;
        rv3 = 1'b0;
        push(1, "l3_load", 0, 32'hCAFEF00D, a1 + 4);
        chk("l3_b2b_spacing", 32'(a1 - a0), 32'd6);
        drain();

        // LATENCY = 3: reset during WAIT abandons the store
        issue(1, "l3_st_init", 1, 32'h20, 2'b10, 0, 32'h11111111, 0, 32'h0, 1, acc);
        drain();
        issue(1, "l3_st_abort", 1, 32'h20, 2'b10, 0, 32'hAAAAAAAA, 0, 32'h0, 0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n3 = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy3), 32'd1);
        chk("abort_valid", 32'(resp_valid3), 32'd0);
        @(negedge clk);
        rst_n3 = 1'b1;
        repeat (8) @(negedge clk);
        issue(1, "l3_ld_after_abort", 0, 32'h20, 2'b10, 0, 32'h0, 0, 32'h11111111, 1, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
